// File: rtl/mops_sdo_pkg.sv
// Shared types, constants and frame builder for the MOPS SDO expedited-upload responder.
// Frame layout: [75] RTR, [74:64] COB-ID, [63:0] payload with byte0 at [63:56].
package mops_sdo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FETCH,
    ST_SEND
  } sdo_state_e;

  localparam logic [10:0] COB_RSDO_BASE = 11'h600;
  localparam logic [10:0] COB_TSDO_BASE = 11'h580;

  localparam logic [7:0] SDO_CMD_UPLOAD_REQ  = 8'h40;
  localparam logic [7:0] SDO_CMD_UPLOAD_EXP2 = 8'h4B;
  localparam logic [7:0] SDO_CMD_ABORT       = 8'h80;

  localparam logic [31:0] ABORT_BAD_CMD = 32'h0504_0001;
  localparam logic [31:0] ABORT_NO_OBJ  = 32'h0602_0000;
  localparam logic [31:0] ABORT_BAD_SUB = 32'h0609_0011;
  localparam logic [31:0] ABORT_HW_ERR  = 32'h0800_0000;

  localparam int FRM_W     = 76;
  localparam int RTR_BIT   = 75;
  localparam int COB_LSB   = 64;
  localparam int CMD_LSB   = 56;
  localparam int IDX_L_LSB = 48;
  localparam int IDX_H_LSB = 40;
  localparam int SUB_LSB   = 32;

  // Index goes out low byte first and data32 little-endian, as CANopen puts them on the wire.
  function automatic logic [FRM_W-1:0] build_sdo_frame(
    input logic [10:0] cob,
    input logic [7:0]  cmd,
    input logic [15:0] idx,
    input logic [7:0]  sub,
    input logic [31:0] data32
  );
    return {1'b0, cob, cmd, idx[7:0], idx[15:8], sub,
            data32[7:0], data32[15:8], data32[23:16], data32[31:24]};
  endfunction

endpackage

// File: rtl/sdo_frame_check.sv
// Combinational classifier for a latched SDO request: address match, then command/index/subindex
// validation in abort-priority order.
module sdo_frame_check
  import mops_sdo_pkg::*;
#(
  parameter logic [6:0]  NODE_ID    = 7'h00,
  parameter logic [15:0] ADC_INDEX  = 16'h2400,
  parameter logic [5:0]  ADC_CH_MAX = 6'd35
) (
  input  logic [FRM_W-1:0] frame,
  output logic             match,
  output logic             ok,
  output logic [31:0]      abort_code
);

  logic [7:0]  cmd;
  logic [15:0] idx;
  logic [7:0]  sub;
  logic        unused_tail;

  assign cmd = frame[CMD_LSB +: 8];
  assign idx = {frame[IDX_H_LSB +: 8], frame[IDX_L_LSB +: 8]};
  assign sub = frame[SUB_LSB +: 8];
  // Bytes 4-7 of an upload request carry nothing we act on.
  assign unused_tail = ^frame[SUB_LSB-1:0];

  assign match = !frame[RTR_BIT] &&
                 (frame[COB_LSB +: 11] == (COB_RSDO_BASE + {4'h0, NODE_ID}));

  always_comb begin
    ok         = 1'b0;
    abort_code = 32'h0;
    if (cmd[7:5] != SDO_CMD_UPLOAD_REQ[7:5]) begin
      abort_code = ABORT_BAD_CMD;
    end else if (idx != ADC_INDEX) begin
      abort_code = ABORT_NO_OBJ;
    end else if (sub == 8'h00 || sub > {2'b00, ADC_CH_MAX}) begin
      abort_code = ABORT_BAD_SUB;
    end else begin
      ok = 1'b1;
    end
  end

endmodule

// File: rtl/mops_sdo_responder.sv
// SDO expedited-upload server: validates a request, fetches one ADC channel over req/ack and
// returns a 0x4B response or an abort frame; holds tx_frame until tx_ready, drops frames while busy.
module mops_sdo_responder
  import mops_sdo_pkg::*;
#(
  parameter logic [6:0]  NODE_ID     = 7'h00,
  parameter logic [15:0] ADC_INDEX   = 16'h2400,
  parameter logic [5:0]  ADC_CH_MAX  = 6'd35,
  parameter int          ADC_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [FRM_W-1:0] rx_frame,
  output logic             adc_req,
  output logic [5:0]       adc_ch,
  input  logic             adc_ack,
  input  logic [11:0]      adc_data,
  output logic             tx_valid,
  output logic [FRM_W-1:0] tx_frame,
  input  logic             tx_ready,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int               TMO_W    = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ADC_TIMEOUT - 1);
  localparam logic [10:0]      TX_COB   = COB_TSDO_BASE + {4'h0, NODE_ID};

  sdo_state_e       state;
  logic [FRM_W-1:0] req_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             chk_match;
  logic             chk_ok;
  logic [31:0]      chk_abort;
  logic [15:0]      req_idx;
  logic [7:0]       req_sub;

  assign req_idx = {req_q[IDX_H_LSB +: 8], req_q[IDX_L_LSB +: 8]};
  assign req_sub = req_q[SUB_LSB +: 8];
  assign busy    = (state != ST_IDLE);

  sdo_frame_check #(
    .NODE_ID    (NODE_ID),
    .ADC_INDEX  (ADC_INDEX),
    .ADC_CH_MAX (ADC_CH_MAX)
  ) u_check (
    .frame      (req_q),
    .match      (chk_match),
    .ok         (chk_ok),
    .abort_code (chk_abort)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      tmo_cnt  <= '0;
      adc_req  <= 1'b0;
      adc_ch   <= 6'd0;
      tx_valid <= 1'b0;
      tx_frame <= '0;
      drop_cnt <= 8'd0;
    end else begin
      if (rx_valid && state != ST_IDLE && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            req_q <= rx_frame;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!chk_match) begin
            state <= ST_IDLE;
          end else if (chk_ok) begin
            adc_ch  <= req_sub[5:0];
            adc_req <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_FETCH;
          end else begin
            tx_frame <= build_sdo_frame(TX_COB, SDO_CMD_ABORT, req_idx, req_sub, chk_abort);
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end
        end
        ST_FETCH: begin
          // A late ack landing on the final timeout cycle still produces data, not an abort.
          if (adc_ack) begin
            adc_req  <= 1'b0;
            tx_frame <= build_sdo_frame(TX_COB, SDO_CMD_UPLOAD_EXP2, req_idx, req_sub,
                                        {20'h0, adc_data});
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end else if (tmo_cnt == TMO_LAST) begin
            adc_req  <= 1'b0;
            tx_frame <= build_sdo_frame(TX_COB, SDO_CMD_ABORT, req_idx, req_sub, ABORT_HW_ERR);
            tx_valid <= 1'b1;
            state    <= ST_SEND;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
